// File: rtl/watchdog_core.sv
// rtl/watchdog_core.sv - armable countdown watchdog with prescaled ticks, kick service and expiry bark
module watchdog_core #(
    parameter int CNT_W     = 32,
    parameter int ELAPSED_W = 16,
    parameter int PRESCALE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 kick,
    input  logic [CNT_W-1:0]     timeout,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     remaining,
    output logic [ELAPSED_W-1:0] elapsed,
    output logic                 kick_ok,
    output logic                 expire,
    output logic                 bark,
    output logic [7:0]           expire_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Prescaler keeps at least one bit so PRESCALE=1 still elaborates cleanly.
    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [ELAPSED_W-1:0] EL_MAX = '1;

    state_t               cur, nxt;
    logic [CNT_W-1:0]     rem_n, tmo_q, tmo_n;
    logic [ELAPSED_W-1:0] el_n;
    logic [PW-1:0]        pre_q, pre_n;
    logic                 kok_n, exp_n, arm, load, tick;
    logic [7:0]           cnt_n;

    assign arm  = start && (timeout != '0);
    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        nxt   = cur;
        rem_n = remaining;
        el_n  = elapsed;
        pre_n = pre_q;
        tmo_n = tmo_q;
        kok_n = 1'b0;
        exp_n = 1'b0;
        cnt_n = expire_cnt;
        load  = 1'b0;
        case (cur)
            IDLE: load = arm;
            RUN: begin
                if (stop) begin
                    nxt = IDLE;
                end else if (kick) begin
                    rem_n = tmo_q;
                    el_n  = '0;
                    pre_n = '0;
                    kok_n = 1'b1;
                end else begin
                    if (elapsed != EL_MAX) el_n = elapsed + ELAPSED_W'(1);
                    if (tick) begin
                        pre_n = '0;
                        if (remaining > CNT_W'(1)) begin
                            rem_n = remaining - CNT_W'(1);
                        end else begin
                            rem_n = '0;
                            nxt   = DONE;
                            exp_n = 1'b1;
                            if (expire_cnt != 8'hFF) cnt_n = expire_cnt + 8'd1;
                        end
                    end else begin
                        pre_n = pre_q + PW'(1);
                    end
                end
            end
            DONE: begin
                if (stop) nxt = IDLE;
                else      load = arm;
            end
            default: nxt = IDLE;
        endcase
        // Arming is shared by IDLE and DONE; stop in DONE takes precedence.
        if (load) begin
            nxt   = RUN;
            tmo_n = timeout;
            rem_n = timeout;
            el_n  = '0;
            pre_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= IDLE;
            remaining  <= '0;
            elapsed    <= '0;
            pre_q      <= '0;
            tmo_q      <= '0;
            kick_ok    <= 1'b0;
            expire     <= 1'b0;
            expire_cnt <= '0;
        end else begin
            cur        <= nxt;
            remaining  <= rem_n;
            elapsed    <= el_n;
            pre_q      <= pre_n;
            tmo_q      <= tmo_n;
            kick_ok    <= kok_n;
            expire     <= exp_n;
            expire_cnt <= cnt_n;
        end
    end

    assign state = cur;
    assign bark  = (cur == DONE);
endmodule

// File: doc/watchdog_core.md
WATCHDOG_CORE -- requirements
Module: watchdog_core

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the countdown width.
REQ-002 The block SHALL have parameter ELAPSED_W, default 16, giving the elapsed-counter width.
REQ-003 The block SHALL have parameter PRESCALE, default 1, giving clk cycles per countdown tick; legal values are 1 or more.
REQ-004 The block SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port start  in  1  arm request, sampled each cycle.
REQ-007 The block SHALL have port stop  in  1  disarm request.
REQ-008 The block SHALL have port kick  in  1  service request that restarts the countdown.
REQ-009 The block SHALL have port timeout  in  CNT_W  reload value, unsigned, latched on an accepted start.
REQ-010 The block SHALL have port state  out  2  state: IDLE=0, RUN=1, DONE=2; value 3 is never driven.
REQ-011 The block SHALL have port remaining  out  CNT_W  current countdown value.
REQ-012 The block SHALL have port elapsed  out  ELAPSED_W  clk cycles since the last start/kick, saturating.
REQ-013 The block SHALL have port kick_ok  out  1  one-cycle pulse acknowledging an accepted kick.
REQ-014 The block SHALL have port expire  out  1  one-cycle pulse on the RUN->DONE transition.
REQ-015 The block SHALL have port bark  out  1  level, high exactly while state==DONE.
REQ-016 The block SHALL have port expire_cnt  out  8  saturating count of expirations.

Function
REQ-017 In IDLE, start with timeout!=0 SHALL latch timeout, load remaining=timeout, clear elapsed and the prescaler, and go to RUN on the next edge.
REQ-018 In IDLE, start with timeout==0 SHALL be ignored: state stays IDLE and no output changes.
REQ-019 In RUN, the input priority SHALL be stop > kick > tick; start SHALL be ignored, and the latched timeout SHALL be unchanged.
REQ-020 In RUN, stop SHALL give state IDLE on the next edge, with remaining and elapsed held.
REQ-021 In RUN, kick SHALL reload remaining from the latched timeout, clear elapsed and the prescaler, and pulse kick_ok in the following cycle.
REQ-022 The prescaler SHALL count 0..PRESCALE-1 in RUN only, and a tick SHALL occur on each edge where the prescaler equals PRESCALE-1 (every edge when PRESCALE=1).
REQ-023 On a tick with remaining>1, remaining SHALL decrement by 1.
REQ-024 On a tick with remaining==1, remaining SHALL become 0, state SHALL become DONE, and expire SHALL be 1 for that first DONE cycle only.
REQ-025 On an expiration, expire_cnt SHALL increment, saturating at 255.
REQ-026 Latency: with PRESCALE=1, a start sampled at edge 0 with timeout=T and no kicks SHALL give state=RUN for T cycles and DONE/expire after edge T.
REQ-027 elapsed SHALL increment every clk cycle in RUN, regardless of prescale, saturating at 2^ELAPSED_W-1, and SHALL hold in IDLE and DONE.
REQ-028 A kick on the same edge as a remaining==1 tick SHALL win: no expiration, remaining reloads.
REQ-029 In DONE, kick SHALL be ignored (kick_ok stays 0); stop SHALL go to IDLE; start with timeout!=0 SHALL re-arm as in REQ-017.
REQ-030 In DONE, start with timeout==0 SHALL be ignored.
REQ-031 All outputs SHALL be registered; none SHALL combinationally depend on inputs.

Reset
REQ-032 rst_n low SHALL, immediately and asynchronously, force state=IDLE, remaining=0, elapsed=0, kick_ok=0, expire=0, bark=0, expire_cnt=0, prescaler=0, and latched timeout=0.
REQ-033 Reset asserted mid-RUN or mid-DONE SHALL abort with no expire pulse, and the block SHALL resume from IDLE on the first edge after rst_n rises.

Verification
REQ-034 Basic expiry: PRESCALE=1, timeout=5, start 1 cycle, no kick -> RUN 5 cycles, remaining 5,4,3,2,1; then DONE, expire 1 cycle, bark=1, expire_cnt=1.
REQ-035 Kick race: timeout=3, kick on the edge where remaining==1 -> no expire, remaining=3, kick_ok pulse, elapsed=0.
REQ-036 Prescale: PRESCALE=4, timeout=2 -> DONE exactly 8 cycles after start, with elapsed=8.
REQ-037 Illegal and saturating cases: start with timeout=0 -> stays IDLE; 256 expirations -> expire_cnt=255; ELAPSED_W=4 with timeout=100 -> elapsed holds at 15.
REQ-038 Stop and reset: stop+kick in the same RUN cycle -> IDLE, kick_ok=0; rst_n low mid-RUN -> all outputs at reset values immediately, without waiting for a clk edge.
